// File: rtl/drum_step_scheduler.sv
// Global timestep sequencer for the drum mesh: initialises the columns, paces the shared
// shoot pulse, captures the centre-node sample per step and recovers from stalled columns.
module drum_step_scheduler #(
  parameter int unsigned        N_COL        = 30,
  parameter int unsigned        STEP_CYCLES  = 1024,
  parameter int unsigned        INIT_CYCLES  = 4,
  parameter int unsigned        TIMEOUT      = 4095,
  parameter logic signed [17:0] DEFAULT_INCR = 18'sd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               pluck,
  input  logic signed [17:0] pluck_incr,
  input  logic [N_COL-1:0]   col_done,
  input  logic signed [17:0] center_node,
  output logic               col_rst,
  output logic               shoot,
  output logic signed [17:0] incr,
  output logic signed [17:0] sample,
  output logic               sample_valid,
  output logic [31:0]        step_count,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned IW = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] PACE_MAX  = PW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_PACE      = 3'd2;
  localparam logic [2:0] S_SHOOT     = 3'd3;
  localparam logic [2:0] S_BLANK     = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [IW-1:0] init_cnt;
  logic [PW-1:0] pace_cnt;
  logic [WW-1:0] wd_cnt;
  logic          all_done;
  logic          waiting;
  logic          timeout_hit;
  logic          step_done;

  assign all_done    = &col_done;
  assign waiting     = (state == S_LOAD) || (state == S_WAIT_DONE);
  // The watchdog fires on the TIMEOUT-th consecutive waiting cycle without completion.
  assign timeout_hit = waiting && (wd_cnt == WD_LAST) && !all_done && !pluck;
  assign step_done   = (state == S_WAIT_DONE) && all_done && !pluck;

  always_comb begin
    state_nxt = state;
    if (pluck) begin
      state_nxt = S_INIT;
    end else begin
      case (state)
        S_INIT:      if (init_cnt == INIT_LAST) state_nxt = S_LOAD;
        S_LOAD:      if (all_done) state_nxt = S_PACE;
                     else if (timeout_hit) state_nxt = S_INIT;
        S_PACE:      if (run && (pace_cnt == PACE_MAX)) state_nxt = S_SHOOT;
        S_SHOOT:     state_nxt = S_BLANK;
        S_BLANK:     state_nxt = S_WAIT_DONE;
        S_WAIT_DONE: if (all_done) state_nxt = S_PACE;
                     else if (timeout_hit) state_nxt = S_INIT;
        default:     state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_INIT;
      init_cnt     <= '0;
      pace_cnt     <= '0;
      wd_cnt       <= '0;
      col_rst      <= 1'b1;
      shoot        <= 1'b0;
      busy         <= 1'b1;
      incr         <= DEFAULT_INCR;
      sample       <= '0;
      sample_valid <= 1'b0;
      step_count   <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      col_rst      <= (state_nxt == S_INIT);
      shoot        <= (state_nxt == S_SHOOT);
      busy         <= (state_nxt != S_PACE);
      sample_valid <= step_done;

      if ((state == S_INIT) && (state_nxt == S_INIT) && !pluck) init_cnt <= init_cnt + 1'b1;
      else init_cnt <= '0;

      // Cleared on entry to S_SHOOT so the shoot cycle itself is count 0 of the period.
      if ((state == S_INIT) || (state_nxt == S_INIT) || (state_nxt == S_SHOOT)) pace_cnt <= '0;
      else if (pace_cnt != PACE_MAX) pace_cnt <= pace_cnt + 1'b1;

      if (waiting && (state_nxt == state)) wd_cnt <= wd_cnt + 1'b1;
      else wd_cnt <= '0;

      if (step_done) sample <= center_node;

      if (pluck) begin
        incr        <= pluck_incr;
        step_count  <= '0;
        timeout_err <= 1'b0;
      end else if (timeout_hit) begin
        step_count  <= '0;
        timeout_err <= 1'b1;
      end else if (step_done) begin
        step_count  <= step_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Self-checking bench for drum_step_scheduler: a column environment model drives col_done,
// and expected event timing is derived from the step rules with plain arithmetic.
`timescale 1ns/1ps
module tb_drum_step_scheduler;

  localparam int unsigned        N_COL    = 30;
  localparam int unsigned        STEP     = 1024;
  localparam int unsigned        INITC    = 4;
  localparam int unsigned        TMO      = 4095;
  localparam logic signed [17:0] DEF_INCR = 18'sd1024;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               run = 1'b0;
  logic               pluck = 1'b0;
  logic signed [17:0] pluck_incr;
  logic [N_COL-1:0]   col_done;
  logic signed [17:0] center_node;
  logic               col_rst, shoot, sample_valid, busy, timeout_err;
  logic signed [17:0] incr, sample;
  logic [31:0]        step_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Column environment: columns go busy when col_rst falls or shoot is seen, keep a stale
  // done for two cycles after shoot, then report done env_delay cycles after the event.
  int                 env_k = 0;
  int                 env_delay = 40;
  logic [N_COL-1:0]   env_stuck = '0;
  logic signed [17:0] env_center = '0;
  logic               prev_col_rst = 1'b1;

  int init_exit = 0;
  int load_delay = 40;
  logic [31:0] exp_steps = '0;

  drum_step_scheduler #(
    .N_COL(N_COL), .STEP_CYCLES(STEP), .INIT_CYCLES(INITC), .TIMEOUT(TMO), .DEFAULT_INCR(DEF_INCR)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .pluck(pluck), .pluck_incr(pluck_incr),
    .col_done(col_done), .center_node(center_node), .col_rst(col_rst), .shoot(shoot),
    .incr(incr), .sample(sample), .sample_valid(sample_valid), .step_count(step_count),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (col_rst) begin
      col_done = '0;
      env_k = 0;
    end else begin
      if (prev_col_rst || shoot) env_k = 0;
      else env_k++;
      if (env_k >= 2) begin
        if (env_k >= env_delay) begin
          if (env_k == env_delay) center_node = env_center;
          col_done = ~env_stuck;
        end else begin
          col_done = '0;
        end
      end
    end
    prev_col_rst = col_rst;
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (col_rst === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic await_shoot(input string nm);
    int n;
    n = 0;
    while (shoot !== 1'b1 && n < 6000) begin
      tick();
      n++;
    end
    checks++;
    if (shoot !== 1'b1) begin
      failures++;
      $display("FAIL %s: no shoot within %0d cycles (shoot=%b, required 1)", nm, n, shoot);
    end
  endtask

  // Starts on the negedge of a shoot cycle, ends on the negedge of the next shoot.
  task automatic do_step(input int d, input logic signed [17:0] cn, input logic [31:0] exp_cnt,
                         input string nm);
    int s, n, sv_n, sv_c;
    logic signed [17:0] sv_v;
    logic [31:0] sc;
    s = cyc; n = 0; sv_n = 0; sv_c = -1; sv_v = '0; sc = '0;
    env_delay = d;
    env_center = cn;
    tick();
    while (shoot !== 1'b1 && n < 6000) begin
      if (sample_valid === 1'b1) begin
        sv_n++; sv_c = cyc; sv_v = sample; sc = step_count;
      end
      tick();
      n++;
    end
    checks++;
    if (sv_n != 1) begin failures++; $display("FAIL %s_sv_pulses: got %0d required 1", nm, sv_n); end
    checks++;
    if (sv_c != s + d + 1) begin
      failures++; $display("FAIL %s_sv_cycle: got %0d required %0d", nm, sv_c, s + d + 1);
    end
    checks++;
    if (sv_v !== cn) begin failures++; $display("FAIL %s_sample: got %0d required %0d", nm, sv_v, cn); end
    checks++;
    if (sc !== exp_cnt) begin
      failures++; $display("FAIL %s_step_count: got %0d required %0d", nm, sc, exp_cnt);
    end
    checks++;
    if (shoot !== 1'b1 || cyc != s + imax(STEP, d + 2)) begin
      failures++;
      $display("FAIL %s_next_shoot: got cycle %0d (shoot=%b) required cycle %0d", nm, cyc, shoot,
               s + imax(STEP, d + 2));
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0; run = 1'b1; env_delay = 40;
    #17;
    checks++;
    if (col_rst !== 1'b1 || shoot !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl: got col_rst=%b shoot=%b busy=%b required 1 0 1", col_rst, shoot, busy);
    end
    checks++;
    if (incr !== DEF_INCR) begin failures++; $display("FAIL reset_incr: got %0d required %0d", incr, DEF_INCR); end
    checks++;
    if (sample !== 18'sd0 || sample_valid !== 1'b0) begin
      failures++; $display("FAIL reset_sample: got %0d/%b required 0/0", sample, sample_valid);
    end
    checks++;
    if (step_count !== 32'd0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL reset_status: got %0d/%b required 0/0", step_count, timeout_err);
    end
    @(negedge clk);
    rst = 1'b1;
    prev_col_rst = 1'b1;
    count_init(n);
    checks++;
    if (n != INITC) begin failures++; $display("FAIL reset_init_len: got %0d required %0d", n, INITC); end
    init_exit = cyc;
  endtask

  task automatic test_first_shoot();
    int n, sv_n;
    logic [31:0] sc_max;
    n = 0; sv_n = 0; sc_max = '0;
    while (shoot !== 1'b1 && n < 6000) begin
      if (sample_valid === 1'b1) sv_n++;
      if (step_count > sc_max) sc_max = step_count;
      tick();
      n++;
    end
    checks++;
    if (shoot !== 1'b1 || cyc != init_exit + imax(STEP, load_delay + 2)) begin
      failures++;
      $display("FAIL first_shoot: got cycle %0d required %0d", cyc - init_exit, imax(STEP, load_delay + 2));
    end
    checks++;
    if (sv_n != 0 || sc_max != 0) begin
      failures++; $display("FAIL load_no_sample: got sv=%0d count=%0d required 0 0", sv_n, sc_max);
    end
    exp_steps = '0;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 3; i++) begin
      exp_steps++;
      do_step(35, 18'sd500, exp_steps, "free_run");
    end
    for (int i = 0; i < 4; i++) begin
      exp_steps++;
      do_step(int'($urandom_range(3, 1200)), 18'($urandom), exp_steps, "rand_step");
    end
  endtask

  task automatic test_pause();
    int s, sv_n, sv_c, sh_n;
    logic [31:0] sc;
    logic signed [17:0] cn;
    await_shoot("pause_sync");
    s = cyc; sv_n = 0; sv_c = -1; sh_n = 0; sc = '0;
    cn = 18'($urandom);
    run = 1'b0; env_delay = 50; env_center = cn;
    for (int i = 0; i < int'(STEP) + 300; i++) begin
      tick();
      if (sample_valid === 1'b1) begin sv_n++; sv_c = cyc; sc = step_count; end
      if (shoot === 1'b1) sh_n++;
    end
    exp_steps++;
    checks++;
    if (sv_n != 1 || sv_c != s + 51) begin
      failures++; $display("FAIL pause_step_done: got %0d pulses at %0d required 1 at %0d", sv_n, sv_c, s + 51);
    end
    checks++;
    if (sc !== exp_steps) begin failures++; $display("FAIL pause_count: got %0d required %0d", sc, exp_steps); end
    checks++;
    if (sh_n != 0) begin failures++; $display("FAIL pause_no_shoot: got %0d shoots required 0", sh_n); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL pause_busy: got %b required 0", busy); end
    run = 1'b1;
    tick();
    checks++;
    if (shoot !== 1'b1) begin failures++; $display("FAIL resume_shoot: got %b required 1", shoot); end
  endtask

  task automatic test_pluck_wait();
    int s, d, sv_n, n;
    await_shoot("pluck_sync");
    s = cyc; sv_n = 0;
    d = int'($urandom_range(40, 300));
    env_delay = d;
    while (cyc < s + d) begin
      tick();
      if (sample_valid === 1'b1) sv_n++;
    end
    pluck = 1'b1; pluck_incr = 18'sd2048; env_delay = 40; load_delay = 40;
    tick();
    pluck = 1'b0;
    checks++;
    if (sv_n != 0 || sample_valid !== 1'b0) begin
      failures++; $display("FAIL pluck_no_sample: got sv=%b (%0d earlier) required 0", sample_valid, sv_n);
    end
    checks++;
    if (col_rst !== 1'b1 || incr !== 18'sd2048) begin
      failures++; $display("FAIL pluck_incr: got col_rst=%b incr=%0d required 1 2048", col_rst, incr);
    end
    checks++;
    if (step_count !== 32'd0) begin failures++; $display("FAIL pluck_count: got %0d required 0", step_count); end
    tick();
    pluck = 1'b1; pluck_incr = -18'sd300;
    tick();
    pluck = 1'b0;
    checks++;
    if (incr !== -18'sd300) begin failures++; $display("FAIL repluck_incr: got %0d required -300", incr); end
    count_init(n);
    checks++;
    if (n != INITC) begin failures++; $display("FAIL repluck_init_len: got %0d required %0d", n, INITC); end
    init_exit = cyc;
  endtask

  task automatic test_pluck_vs_shoot();
    int n;
    logic signed [17:0] v;
    while (cyc < init_exit + int'(STEP) - 1) tick();
    v = 18'($urandom);
    if (v == DEF_INCR) v = 18'sd2047;
    pluck = 1'b1; pluck_incr = v;
    tick();
    pluck = 1'b0;
    checks++;
    if (shoot !== 1'b0 || col_rst !== 1'b1) begin
      failures++; $display("FAIL pluck_beats_shoot: got shoot=%b col_rst=%b required 0 1", shoot, col_rst);
    end
    checks++;
    if (incr !== v) begin failures++; $display("FAIL pluck_shoot_incr: got %0d required %0d", incr, v); end
    load_delay = int'($urandom_range(3, 1100));
    env_delay = load_delay;
    count_init(n);
    checks++;
    if (n != INITC) begin failures++; $display("FAIL pluck_init_len: got %0d required %0d", n, INITC); end
    init_exit = cyc;
  endtask

  task automatic test_timeout();
    int s, n;
    logic signed [17:0] v;
    await_shoot("timeout_sync");
    checks++;
    if (cyc != init_exit + imax(STEP, load_delay + 2)) begin
      failures++;
      $display("FAIL rand_load_shoot: got cycle %0d required %0d", cyc - init_exit, imax(STEP, load_delay + 2));
    end
    do_step(35, 18'($urandom), 32'd1, "pre_timeout");
    s = cyc; n = 0;
    env_stuck = N_COL'(1) << $urandom_range(0, N_COL - 1);
    env_delay = 40;
    while (timeout_err !== 1'b1 && n < int'(TMO) + 200) begin
      tick();
      n++;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc != s + 2 + int'(TMO)) begin
      failures++;
      $display("FAIL timeout_time: got %0d cycles after shoot (err=%b) required %0d", cyc - s, timeout_err, 2 + TMO);
    end
    checks++;
    if (col_rst !== 1'b1 || step_count !== 32'd0) begin
      failures++; $display("FAIL timeout_reinit: got col_rst=%b count=%0d required 1 0", col_rst, step_count);
    end
    env_stuck = '0; env_delay = 30;
    count_init(n);
    checks++;
    if (n != INITC) begin failures++; $display("FAIL timeout_init_len: got %0d required %0d", n, INITC); end
    await_shoot("timeout_resume");
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
    do_step(35, 18'($urandom), 32'd1, "post_timeout");
    v = 18'($urandom);
    if (v == DEF_INCR) v = -18'sd7;
    pluck = 1'b1; pluck_incr = v; env_delay = 20;
    tick();
    pluck = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || col_rst !== 1'b1) begin
      failures++; $display("FAIL timeout_clear: got err=%b col_rst=%b required 0 1", timeout_err, col_rst);
    end
    count_init(n);
  endtask

  task automatic test_async_reset();
    int n;
    await_shoot("areset_sync");
    #2;
    rst = 1'b0;
    col_done = '0;
    #1;
    checks++;
    if (shoot !== 1'b0 || col_rst !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_ctrl: got shoot=%b col_rst=%b busy=%b required 0 1 1", shoot, col_rst, busy);
    end
    checks++;
    if (incr !== DEF_INCR || step_count !== 32'd0) begin
      failures++; $display("FAIL areset_state: got incr=%0d count=%0d required %0d 0", incr, step_count, DEF_INCR);
    end
    @(negedge clk);
    rst = 1'b1;
    prev_col_rst = 1'b1;
    count_init(n);
    checks++;
    if (n != INITC) begin failures++; $display("FAIL areset_init_len: got %0d required %0d", n, INITC); end
  endtask

  initial begin
    col_done = '0; center_node = '0; pluck_incr = '0;
    test_reset();
    test_first_shoot();
    test_free_run();
    test_pause();
    test_pluck_wait();
    test_pluck_vs_shoot();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation exceeded 3 ms, required completion");
    $fatal(1, "global timeout");
  end

endmodule
